decoder_binario: RTL and testbench

//   Binary-to-one-hot decoder: a 4-bit code selects exactly one of 16 output lines.

---
 rtl/decoder_binario_pkg.sv | 13 +
 rtl/decoder_binario_chk.sv | 18 +
 rtl/decoder_binario_core.sv | 23 ++
 rtl/decoder_binario.sv | 70 +++++++
 tb/tb_decoder_binario.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/decoder_binario_pkg.sv
// Shared constants and the one-hot helper for the binary-to-one-hot decoder.
// The helper works at the widest supported code so any IN_W in 1..8 is exact.
package decoder_binario_pkg;

  localparam int DEF_IN_W = 4;
  localparam int MAX_IN_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_IN_W;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] code);
    onehot = {{(MAX_OUT_W-1){1'b0}}, 1'b1} << code;
  endfunction

endpackage

// File: rtl/decoder_binario_chk.sv
// One-hot invariant on a registered decoder: one active line when valid, none otherwise.
module decoder_binario_chk #(
  parameter int OUT_W      = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic             clk,
  input logic             rst,
  input logic [OUT_W-1:0] out,
  input logic             valid
);

  logic [OUT_W-1:0] act_s;
  assign act_s = ACTIVE_LOW ? ~out : out;

  a_onehot_valid: assert property (@(posedge clk) disable iff (rst) valid |-> $onehot(act_s));
  a_idle_invalid: assert property (@(posedge clk) disable iff (rst) !valid |-> (act_s == {OUT_W{1'b0}}));

endmodule

// File: rtl/decoder_binario_core.sv
// Combinational decode: exactly one bit of dec_o set for an enabled, fully known code.
module decoder_binario_core
  import decoder_binario_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = 2 ** IN_W
) (
  input  logic             en_i,
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] dec_o
);

  // An unknown code must never select a target, so it decodes to nothing.
  always_comb begin
    dec_o = {OUT_W{1'b0}};
    if (en_i && !$isunknown(in_i)) begin
      dec_o = OUT_W'(onehot(MAX_IN_W'(in_i)));
    end else begin
      dec_o = {OUT_W{1'b0}};
    end
  end

endmodule

// File: rtl/decoder_binario.sv
// Binary-to-one-hot select decoder with optional output register, polarity
// control and a registered valid flag.
module decoder_binario
  import decoder_binario_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter bit REGISTERED = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int OUT_W     = 2 ** IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             valid
);

  localparam logic [OUT_W-1:0] IDLE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [OUT_W-1:0] dec_s;
  logic [OUT_W-1:0] pol_s;
  logic             valid_q;
  logic             valid_d;

  decoder_binario_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .en_i  (en),
    .in_i  (in),
    .dec_o (dec_s)
  );

  assign pol_s   = ACTIVE_LOW ? ~dec_s : dec_s;
  assign valid_d = en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

  generate
    if (REGISTERED) begin : g_reg
      logic [OUT_W-1:0] out_q;
      logic [OUT_W-1:0] out_d;

      assign out_d = pol_s;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q <= IDLE;
        end else begin
          out_q <= out_d;
        end
      end

      assign out = out_q;
    end else begin : g_comb
      // Reset still forces the lines inactive even without a register stage.
      assign out = rst ? IDLE : pol_s;
    end
  endgenerate

endmodule

// File: tb/tb_decoder_binario.sv
// Self-checking bench for decoder_binario: default, active-low and combinational builds.
module tb_decoder_binario;

  typedef struct packed {
    logic [15:0] out;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  in_s;
  logic [15:0] out_s, out_al_s, out_cb_s;
  logic        valid_s, valid_al_s, valid_cb_s;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  decoder_binario #(.IN_W(4), .REGISTERED(1'b1), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .in(in_s), .out(out_s), .valid(valid_s));

  decoder_binario #(.IN_W(4), .REGISTERED(1'b1), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .en(en), .in(in_s), .out(out_al_s), .valid(valid_al_s));

  decoder_binario #(.IN_W(4), .REGISTERED(1'b0), .ACTIVE_LOW(1'b0)) u_dut_cb (
    .clk(clk), .rst(rst), .en(en), .in(in_s), .out(out_cb_s), .valid(valid_cb_s));

  decoder_binario_chk #(.OUT_W(16), .ACTIVE_LOW(1'b0)) u_chk (
    .clk(clk), .rst(rst), .out(out_s), .valid(valid_s));

  decoder_binario_chk #(.OUT_W(16), .ACTIVE_LOW(1'b1)) u_chk_al (
    .clk(clk), .rst(rst), .out(out_al_s), .valid(valid_al_s));

  // Drive one code at the falling edge and queue what the registered DUT must show next cycle.
  task automatic drive(input logic e, input logic [3:0] c);
    exp_t x;
    @(negedge clk);
    en   = e;
    in_s = c;
    x.out   = e ? (16'h0001 << c) : 16'h0000;
    x.valid = e;
    sb_q.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; in_s = 4'h0;
    #1;
    checks++;
    if (out_s !== 16'h0000 || valid_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_default: out=%h valid=%b required out=0000 valid=0", out_s, valid_s);
    end
    checks++;
    if (out_al_s !== 16'hFFFF || valid_al_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_active_low: out=%h valid=%b required out=ffff valid=0", out_al_s, valid_al_s);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    exp_t x;
    int ones;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i));
      @(posedge clk); #1;
      x = sb_q.pop_front();
      checks++;
      if (out_s !== x.out || valid_s !== x.valid) begin
        errors++;
        $display("FAIL sweep_%0d: out=%h valid=%b required out=%h valid=%b", i, out_s, valid_s, x.out, x.valid);
      end
      ones = $countones(out_s);
      checks++;
      if (ones != 1) begin
        errors++;
        $display("FAIL sweep_onehot_%0d: bits set=%0d required 1", i, ones);
      end
    end
  endtask

  task automatic test_enable();
    exp_t x;
    drive(1'b0, 4'b0101);
    @(posedge clk); #1;
    x = sb_q.pop_front();
    checks++;
    if (out_s !== x.out || valid_s !== x.valid || out_s !== 16'h0000) begin
      errors++;
      $display("FAIL enable_off: out=%h valid=%b required out=0000 valid=0", out_s, valid_s);
    end
    drive(1'b1, 4'b0101);
    @(posedge clk); #1;
    x = sb_q.pop_front();
    checks++;
    if (out_s !== x.out || valid_s !== x.valid || out_s !== 16'h0020) begin
      errors++;
      $display("FAIL enable_on: out=%h valid=%b required out=0020 valid=1", out_s, valid_s);
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    logic [3:0] codes [6] = '{4'b0000, 4'b1111, 4'b0000, 4'b1000, 4'b1111, 4'b0001};
    logic [15:0] bound [6] = '{16'h0001, 16'h8000, 16'h0001, 16'h0100, 16'h8000, 16'h0002};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, codes[i]);
      @(posedge clk); #1;
      x = sb_q.pop_front();
      checks++;
      if (out_s !== x.out || out_s !== bound[i] || valid_s !== 1'b1) begin
        errors++;
        $display("FAIL boundary_%0d: out=%h valid=%b required out=%h valid=1", i, out_s, valid_s, bound[i]);
      end
    end
  endtask

  task automatic test_midrun_reset();
    exp_t x;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'(i));
      @(posedge clk); #1;
      x = sb_q.pop_front();
      checks++;
      if (out_s !== x.out || valid_s !== x.valid) begin
        errors++;
        $display("FAIL midrun_pre_%0d: out=%h required %h", i, out_s, x.out);
      end
    end
    drive(1'b1, 4'd7);
    #2;
    rst = 1'b1;
    #1;
    sb_q.delete();
    checks++;
    if (out_s !== 16'h0000 || valid_s !== 1'b0) begin
      errors++;
      $display("FAIL midrun_async_clear: out=%h valid=%b required out=0000 valid=0", out_s, valid_s);
    end
    @(posedge clk); #1;
    checks++;
    if (out_s !== 16'h0000 || valid_s !== 1'b0) begin
      errors++;
      $display("FAIL midrun_held: out=%h valid=%b required out=0000 valid=0", out_s, valid_s);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 4'd9);
    @(posedge clk); #1;
    x = sb_q.pop_front();
    checks++;
    if (out_s !== x.out || out_s !== 16'h0200 || valid_s !== 1'b1) begin
      errors++;
      $display("FAIL midrun_release: out=%h valid=%b required out=0200 valid=1", out_s, valid_s);
    end
  endtask

  task automatic test_active_low();
    drive(1'b1, 4'b0011);
    @(posedge clk); #1;
    void'(sb_q.pop_front());
    checks++;
    if (out_al_s !== 16'hFFF7 || valid_al_s !== 1'b1) begin
      errors++;
      $display("FAIL active_low: out=%h valid=%b required out=fff7 valid=1", out_al_s, valid_al_s);
    end
  endtask

  task automatic test_comb();
    drive(1'b1, 4'd12);
    #1;
    checks++;
    if (out_cb_s !== 16'h1000) begin
      errors++;
      $display("FAIL comb_out: out=%h required 1000", out_cb_s);
    end
    @(posedge clk); #1;
    void'(sb_q.pop_front());
    checks++;
    if (valid_cb_s !== 1'b1) begin
      errors++;
      $display("FAIL comb_valid: valid=%b required 1", valid_cb_s);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_cb_s !== 16'h0000 || valid_cb_s !== 1'b0) begin
      errors++;
      $display("FAIL comb_reset: out=%h valid=%b required out=0000 valid=0", out_cb_s, valid_cb_s);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_enable();
    test_back_to_back();
    test_midrun_reset();
    test_active_low();
    test_comb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
